// File: rtl/pit_pkg.sv
// Shared types and constants for the minipit channel scheduler.
// Register addresses and control-byte bit positions follow the timer's config port.
package pit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_W_CFG,
        ST_W_HI,
        ST_W_LO,
        ST_WAIT_ARM,
        ST_DONE
    } pit_state_t;

    localparam logic [1:0] CFG_ADDR_CTRL = 2'b00;
    localparam logic [1:0] CFG_ADDR_HI   = 2'b01;
    localparam logic [1:0] CFG_ADDR_LO   = 2'b10;

    localparam int CTRL_DIV_BIT = 7;
    localparam int CTRL_REP_BIT = 6;

endpackage

// File: rtl/pit_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the first valid requester at or after the pointer.
// The pointer advances past the winner on every accepted grant.
module pit_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    win_id,
    output logic               any_grant
);

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0] ptr;
    logic [ID_W:0]   slot;
    logic [ID_W-1:0] idx;

    // Scan from the pointer with wrap; the first hit wins.
    always_comb begin
        grant     = '0;
        win_id    = '0;
        any_grant = 1'b0;
        slot      = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = {1'b0, ptr} + (ID_W+1)'(k);
            if (slot >= NUM_REQ_W) begin
                slot = slot - NUM_REQ_W;
            end
            idx = slot[ID_W-1:0];
            if (enable && !any_grant && req_valid[idx]) begin
                grant[idx] = 1'b1;
                win_id     = idx;
                any_grant  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (any_grant) begin
            ptr <= (win_id == LAST_ID) ? '0 : win_id + 1'b1;
        end
    end

endmodule

// File: rtl/pit_channel_scheduler.sv
// Shares one minipit timer among NUM_REQ requesters: arbitrate, reset the timer,
// replay the 3-beat config write, confirm arming, then route the timer IRQ to the owner.
module pit_channel_scheduler
    import pit_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ARM_TIMEOUT = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_count,
    input  logic [NUM_REQ-1:0]    req_divider,
    input  logic [NUM_REQ-1:0]    req_repeat,
    output logic [NUM_REQ-1:0]    req_grant,
    output logic                  busy,
    output logic                  done_valid,
    output logic [ID_W-1:0]       done_id,
    output logic                  done_err,
    output logic                  timer_rst,
    output logic                  cfg_we,
    output logic [1:0]            cfg_addr,
    output logic [7:0]            cfg_data,
    input  logic                  timer_armed,
    input  logic                  timer_irq,
    output logic [NUM_REQ-1:0]    irq_out,
    output logic [ID_W-1:0]       owner_id,
    output logic                  owner_valid
);

    localparam int          TO_W    = $clog2(ARM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ARM_TIMEOUT - 1);

    pit_state_t      state;
    pit_state_t      state_next;
    logic            arb_enable;
    logic            any_grant;
    logic [ID_W-1:0] win_id;
    logic [15:0]     lat_count;
    logic            lat_div;
    logic            lat_rep;
    logic [TO_W-1:0] to_cnt;
    logic            arm_expired;

    // Grants only while idle and never during the reset cycle itself.
    assign arb_enable  = (state == ST_IDLE) && !reset;
    assign arm_expired = (to_cnt == TO_LAST);

    pit_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .enable    (arb_enable),
        .grant     (req_grant),
        .win_id    (win_id),
        .any_grant (any_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (any_grant) state_next = ST_CLR;
            ST_CLR:      state_next = ST_W_CFG;
            ST_W_CFG:    state_next = ST_W_HI;
            ST_W_HI:     state_next = ST_W_LO;
            ST_W_LO:     state_next = ST_WAIT_ARM;
            ST_WAIT_ARM: if (timer_armed || arm_expired) state_next = ST_DONE;
            ST_DONE:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        done_valid = 1'b0;
        timer_rst  = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = CFG_ADDR_CTRL;
        cfg_data   = 8'h00;
        case (state)
            ST_CLR: timer_rst = 1'b1;
            ST_W_CFG: begin
                cfg_we                 = 1'b1;
                cfg_addr               = CFG_ADDR_CTRL;
                cfg_data[CTRL_DIV_BIT] = lat_div;
                cfg_data[CTRL_REP_BIT] = lat_rep;
            end
            ST_W_HI: begin
                cfg_we   = 1'b1;
                cfg_addr = CFG_ADDR_HI;
                cfg_data = lat_count[15:8];
            end
            ST_W_LO: begin
                cfg_we   = 1'b1;
                cfg_addr = CFG_ADDR_LO;
                cfg_data = lat_count[7:0];
            end
            ST_DONE: done_valid = 1'b1;
            default: ;
        endcase
    end

    // Ownership drops at grant so an IRQ from the outgoing configuration is never routed.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_count   <= '0;
            lat_div     <= 1'b0;
            lat_rep     <= 1'b0;
            done_id     <= '0;
            done_err    <= 1'b0;
            owner_id    <= '0;
            owner_valid <= 1'b0;
            to_cnt      <= '0;
            irq_out     <= '0;
        end else begin
            irq_out <= (owner_valid && timer_irq) ? (NUM_REQ'(1) << owner_id) : '0;
            case (state)
                ST_IDLE: begin
                    if (any_grant) begin
                        lat_count   <= req_count[16*win_id +: 16];
                        lat_div     <= req_divider[win_id];
                        lat_rep     <= req_repeat[win_id];
                        done_id     <= win_id;
                        owner_valid <= 1'b0;
                    end
                end
                ST_W_LO: to_cnt <= '0;
                ST_WAIT_ARM: begin
                    if (timer_armed) begin
                        owner_id    <= done_id;
                        owner_valid <= 1'b1;
                        done_err    <= 1'b0;
                    end else if (arm_expired) begin
                        done_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pit_channel_scheduler.sv
// Directed bench for pit_channel_scheduler: programming sequence, round-robin order,
// arm timeout, IRQ routing, boundary config bytes and mid-sequence reset.
module tb_pit_channel_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int ARM_TIMEOUT = 4;
    localparam int ID_W        = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_count;
    logic [NUM_REQ-1:0]    req_divider;
    logic [NUM_REQ-1:0]    req_repeat;
    logic [NUM_REQ-1:0]    req_grant;
    logic                  busy;
    logic                  done_valid;
    logic [ID_W-1:0]       done_id;
    logic                  done_err;
    logic                  timer_rst;
    logic                  cfg_we;
    logic [1:0]            cfg_addr;
    logic [7:0]            cfg_data;
    logic                  timer_armed;
    logic                  timer_irq;
    logic [NUM_REQ-1:0]    irq_out;
    logic [ID_W-1:0]       owner_id;
    logic                  owner_valid;

    int checks = 0;
    int errors = 0;
    int order[6] = '{0, 1, 2, 3, 0, 3};

    pit_channel_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .ARM_TIMEOUT (ARM_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_count   (req_count),
        .req_divider (req_divider),
        .req_repeat  (req_repeat),
        .req_grant   (req_grant),
        .busy        (busy),
        .done_valid  (done_valid),
        .done_id     (done_id),
        .done_err    (done_err),
        .timer_rst   (timer_rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .timer_armed (timer_armed),
        .timer_irq   (timer_irq),
        .irq_out     (irq_out),
        .owner_id    (owner_id),
        .owner_valid (owner_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input int id,
                                 input logic [15:0] count, input logic div, input logic rep);
        req_count[16*id +: 16] = count;
        req_divider[id]        = div;
        req_repeat[id]         = rep;
        req_valid              = valid;
        #1;
    endtask

    // Called in the CLR cycle; leaves the bench in the low-byte write cycle.
    task automatic checkWrites(input string tag, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        step();
        checkOutput({tag, "_we0"}, 32'(cfg_we), 32'd1);
        checkOutput({tag, "_addr0"}, 32'(cfg_addr), 32'd0);
        checkOutput({tag, "_data0"}, 32'(cfg_data), 32'(d0));
        step();
        checkOutput({tag, "_we1"}, 32'(cfg_we), 32'd1);
        checkOutput({tag, "_addr1"}, 32'(cfg_addr), 32'd1);
        checkOutput({tag, "_data1"}, 32'(cfg_data), 32'(d1));
        step();
        checkOutput({tag, "_we2"}, 32'(cfg_we), 32'd1);
        checkOutput({tag, "_addr2"}, 32'(cfg_addr), 32'd2);
        checkOutput({tag, "_data2"}, 32'(cfg_data), 32'(d2));
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_count   = '0;
        req_divider = '0;
        req_repeat  = '0;
        timer_armed = 1'b0;
        timer_irq   = 1'b0;
        doReset();

        // Reset state
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_grant", 32'(req_grant), 32'd0);
        checkOutput("rst_owner_valid", 32'(owner_valid), 32'd0);
        checkOutput("rst_irq_out", 32'(irq_out), 32'd0);
        checkOutput("rst_cfg_we", 32'(cfg_we), 32'd0);
        checkOutput("rst_done_valid", 32'(done_valid), 32'd0);

        // Single request for requester 2
        applyStimulus(4'b0100, 2, 16'h1234, 1'b0, 1'b1);
        checkOutput("t1_grant", 32'(req_grant), 32'h4);
        step();
        req_valid = '0;
        checkOutput("t1_timer_rst", 32'(timer_rst), 32'd1);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_done_id", 32'(done_id), 32'd2);
        checkWrites("t1", 8'h40, 8'h12, 8'h34);
        step();
        timer_armed = 1'b1;
        checkOutput("t1_cfg_we_idle", 32'(cfg_we), 32'd0);
        checkOutput("t1_no_done_yet", 32'(done_valid), 32'd0);
        step();
        checkOutput("t1_done_valid", 32'(done_valid), 32'd1);
        checkOutput("t1_done_err", 32'(done_err), 32'd0);
        checkOutput("t1_owner_id", 32'(owner_id), 32'd2);
        checkOutput("t1_owner_valid", 32'(owner_valid), 32'd1);
        timer_armed = 1'b0;
        step();
        checkOutput("t1_done_pulse", 32'(done_valid), 32'd0);

        // Round-robin from reset with the timer arming immediately
        doReset();
        timer_armed = 1'b1;
        applyStimulus(4'b1111, 0, 16'h0010, 1'b0, 1'b1);
        for (int n = 0; n < 6; n++) begin
            for (int c = 0; c < 7; c++) begin
                checkOutput($sformatf("t2_grant_n%0d_c%0d", n, c), 32'(req_grant),
                            (c == 0) ? (32'd1 << order[n]) : 32'd0);
                if (c == 1 && n == 3) req_valid = 4'b1001;
                if (c == 1 && n == 5) req_valid = 4'b0000;
                step();
            end
        end
        checkOutput("t2_owner_id", 32'(owner_id), 32'd3);
        checkOutput("t2_owner_valid", 32'(owner_valid), 32'd1);

        // IRQ during CLR..WAIT_ARM is dropped; then routed to new owner 1
        applyStimulus(4'b0010, 1, 16'h0100, 1'b0, 1'b1);
        checkOutput("t4_grant", 32'(req_grant), 32'h2);
        step();
        req_valid = '0;
        timer_irq = 1'b1;
        for (int c = 2; c <= 6; c++) begin
            step();
            checkOutput($sformatf("t4_irq_drop_c%0d", c), 32'(irq_out), 32'd0);
        end
        checkOutput("t4_done_valid", 32'(done_valid), 32'd1);
        checkOutput("t4_owner_id", 32'(owner_id), 32'd1);
        checkOutput("t4_owner_valid", 32'(owner_valid), 32'd1);
        timer_irq = 1'b0;
        step();
        checkOutput("t4_irq_quiet", 32'(irq_out), 32'd0);
        timer_irq = 1'b1;
        step();
        checkOutput("t4_irq_routed", 32'(irq_out), 32'h2);
        timer_irq = 1'b0;
        step();
        checkOutput("t4_irq_cleared", 32'(irq_out), 32'd0);

        // Arm timeout for requester 0 with timer_irq held high
        timer_armed = 1'b0;
        timer_irq   = 1'b1;
        applyStimulus(4'b0001, 0, 16'h0005, 1'b0, 1'b0);
        checkOutput("t3_grant", 32'(req_grant), 32'h1);
        step();
        req_valid = '0;
        for (int c = 2; c <= 10; c++) begin
            step();
            checkOutput($sformatf("t3_done_c%0d", c), 32'(done_valid), (c == 9) ? 32'd1 : 32'd0);
            checkOutput($sformatf("t3_irq_c%0d", c), 32'(irq_out), 32'd0);
            if (c == 9) begin
                checkOutput("t3_done_err", 32'(done_err), 32'd1);
                checkOutput("t3_done_id", 32'(done_id), 32'd0);
                checkOutput("t3_owner_valid", 32'(owner_valid), 32'd0);
            end
        end
        checkOutput("t3_idle", 32'(busy), 32'd0);
        timer_irq = 1'b0;

        // Boundary config bytes: all-ones count with divider, then zero count
        timer_armed = 1'b1;
        applyStimulus(4'b0010, 1, 16'hFFFF, 1'b1, 1'b0);
        checkOutput("t5a_grant", 32'(req_grant), 32'h2);
        step();
        req_valid = '0;
        checkWrites("t5a", 8'h80, 8'hFF, 8'hFF);
        step();
        step();
        checkOutput("t5a_done_valid", 32'(done_valid), 32'd1);
        checkOutput("t5a_done_err", 32'(done_err), 32'd0);
        checkOutput("t5a_owner_id", 32'(owner_id), 32'd1);
        step();
        applyStimulus(4'b0100, 2, 16'h0000, 1'b0, 1'b0);
        checkOutput("t5b_grant", 32'(req_grant), 32'h4);
        step();
        req_valid = '0;
        checkWrites("t5b", 8'h00, 8'h00, 8'h00);
        step();
        step();
        checkOutput("t5b_done_valid", 32'(done_valid), 32'd1);
        checkOutput("t5b_owner_id", 32'(owner_id), 32'd2);
        step();

        // Reset during the high-byte write
        applyStimulus(4'b1001, 3, 16'h00AA, 1'b0, 1'b1);
        checkOutput("t6_grant", 32'(req_grant), 32'h8);
        step();
        step();
        step();
        checkOutput("t6_in_w_hi", 32'(cfg_addr), 32'd1);
        reset = 1'b1;
        step();
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_grant_in_reset", 32'(req_grant), 32'd0);
        checkOutput("t6_cfg_we", 32'(cfg_we), 32'd0);
        checkOutput("t6_cfg_data", 32'(cfg_data), 32'd0);
        checkOutput("t6_timer_rst", 32'(timer_rst), 32'd0);
        checkOutput("t6_done_valid", 32'(done_valid), 32'd0);
        checkOutput("t6_done_id", 32'(done_id), 32'd0);
        checkOutput("t6_owner_valid", 32'(owner_valid), 32'd0);
        checkOutput("t6_owner_id", 32'(owner_id), 32'd0);
        checkOutput("t6_irq_out", 32'(irq_out), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("t6_grant_after", 32'(req_grant), 32'h1);
        step();
        req_valid = '0;
        checkOutput("t6_no_done", 32'(done_valid), 32'd0);
        for (int c = 2; c <= 6; c++) step();
        checkOutput("t6_done_valid_new", 32'(done_valid), 32'd1);
        checkOutput("t6_done_id_new", 32'(done_id), 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
